seven_seg_scanner: RTL

//   Time-multiplexed hex driver for a common-anode/cathode 7-segment display bank.

---
 rtl/seven_seg_scanner.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed hex driver for a bank of 7-segment digits. A level from the
// upstream clock divider arrives on tick_in; each rising edge of that level
// advances the scan to the next digit. Between two driven digits the display
// is held dark for one clock so the previous digit's segments never bleed
// onto the next anode (ghosting guard).
//
// The digit values, decimal points and blank flags are captured into a
// snapshot when scanning starts and again each time the scan wraps back to
// digit 0. A whole frame therefore always shows one coherent value.
//
// All display outputs are decoded from registered state and snapshot only.
// No input reaches an output in the same cycle.
//
// Handshake / timing contract:
//   tick_in is a free-running level, not a valid/ready pair. Only its rising
//   edge (tick_in high now, low on the previous clock) counts. An edge seen
//   while the display is in its dark gap, or while scanning is off, is simply
//   dropped. enable low always wins over an edge.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (2..8)
//   ACTIVE_LOW  1: an/seg/dp low-active, 0: high-active
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   tick_in     divider output level; rising edge advances the scan
//   enable      1: scan, 0: display dark and index held at 0
//   value       packed hex digits, digit i = value[4i+3:4i], digit 0 = LSD
//   dp_in       decimal point request per digit
//   blank_in    1: digit i dark (anode, segments and dp off)
//   an          anode select, an[i] drives digit i
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point segment
//   digit_idx   digit currently selected
//   frame_done  one-cycle pulse after the scan wraps to digit 0
//   state_dbg   current FSM state (OFF=0, GAP=1, DRIVE=2)
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick_in,
  input  logic                            enable,
  input  logic [4*NUM_DIGITS-1:0]         value,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic [NUM_DIGITS-1:0]           blank_in,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [6:0]                      seg,
  output logic                            dp,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_done,
  output logic [1:0]                      state_dbg
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GAP   = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      tick_q;
  logic [4*NUM_DIGITS-1:0]   snap_value_q, snap_value_d;
  logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]     snap_blank_q, snap_blank_d;
  logic                      frame_done_q, frame_done_d;

  // Rising edge of the divider level. A level held high produces one edge.
  logic tick_edge;
  assign tick_edge = tick_in & ~tick_q;

  // ---------------------------------------------------------------------------
  // Hex to segment decode, active-high form {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      tick_q       <= 1'b0;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tick_q       <= tick_in;
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_value_d = snap_value_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    frame_done_d = 1'b0;

    if (!enable) begin
      // Disabling wins over any pending edge and parks the index at 0.
      state_d = ST_OFF;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d      = ST_GAP;
          idx_d        = '0;
          snap_value_d = value;
          snap_dp_d    = dp_in;
          snap_blank_d = blank_in;
        end

        // One dark clock before every digit; edges here are dropped.
        ST_GAP: begin
          state_d = ST_DRIVE;
        end

        ST_DRIVE: begin
          if (tick_edge) begin
            state_d = ST_GAP;
            if (idx_q == LAST_IDX) begin
              // Wrap: start a new frame from a fresh snapshot.
              idx_d        = '0;
              snap_value_d = value;
              snap_dp_d    = dp_in;
              snap_blank_d = blank_in;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_OFF;
          idx_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state and snapshot only)
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_act;
  logic [6:0]            seg_act;
  logic                  dp_act;
  logic [3:0]            cur_nib;

  assign cur_nib = snap_value_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    an_act  = '0;
    seg_act = '0;
    dp_act  = 1'b0;
    if (state_q == ST_DRIVE && !snap_blank_q[idx_q]) begin
      an_act  = NUM_DIGITS'(1) << idx_q;
      seg_act = hex_decode(cur_nib);
      dp_act  = snap_dp_q[idx_q];
    end
  end

  // Polarity applied last so "inactive" is all-zero in the active-high form.
  assign an         = an_act ^ {NUM_DIGITS{ACTIVE_LOW}};
  assign seg        = seg_act ^ {7{ACTIVE_LOW}};
  assign dp         = dp_act ^ ACTIVE_LOW;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state_q;

endmodule
